run_ctrl: RTL and testbench
===========================

# run_ctrl

Synthesizable run sequencer and trace capture for the CPU `chip`. It generalises the bench bring-up sequence (pre-reset idle, core reset pulse, settle, `start`, cycle-limited run) into a parametrised hardware block. It watches NUM_CH valid/data channels from the core, such as instruction-fetch and data-fetch, and records them in a readable trace FIFO. It sits between the top-level clock/reset and the core's `rst_n`/`start` pins, so on-chip or FPGA runs no longer depend on a testbench to drive them.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each channel's data and of trace entries
- NUM_CH, 2, number of monitored channels (≥2)
- PRE_RST_CYC, 4, cycles with core reset released before the reset pulse (≥1)
- RST_CYC, 2, cycles core reset is asserted (≥1)
- SETTLE_CYC, 2, cycles between reset release and `start` (≥1)
- MAX_CYC, 60, RUN-phase cycle limit (≥1, < 2^CNT_WIDTH)
- TRACE_DEPTH, 16, trace FIFO entries (power of two, ≥2)
- CNT_WIDTH, 16, width of `cycle_cnt`, `drop_cnt` and the phase counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run_req  in  1  level request to run; sampled in IDLE and DONE
- halt  in  1  core end-of-program indication; sampled in RUN only
- ch_valid  in  NUM_CH  per-channel valid
- ch_data  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- core_rst_n  out  1  reset to the core, active-low
- start  out  1  core start
- busy  out  1  state is not IDLE and not DONE
- done  out  1  sticky; run ended by halt
- timeout  out  1  sticky; run ended by reaching MAX_CYC
- cycle_cnt  out  CNT_WIDTH  RUN-cycle index
- trace_rd  in  1  pop request
- trace_data  out  DATA_WIDTH  head entry data (show-ahead)
- trace_ch  out  $clog2(NUM_CH)  head entry channel index
- trace_empty / trace_full  out  1  FIFO status
- overflow  out  1  sticky; a capture was attempted while full
- drop_cnt  out  CNT_WIDTH  saturating count of simultaneous valids that lost arbitration

## Operation
- FSM states: IDLE → PRE → RST → SETTLE → RUN → DONE → IDLE.
- IDLE→PRE when run_req=1. Entering PRE clears done, timeout, overflow, drop_cnt, cycle_cnt and empties the FIFO.
- PRE, RST and SETTLE each last exactly their parameter's cycle count. A phase counter loads length−1 on phase entry and advances the FSM when it reads 0.
- core_rst_n=0 only in RST. start=1 only in RUN. Both are decoded from the state register, with no combinational input path.
- In RUN, cycle_cnt is 0 on the first cycle and increments each cycle.
- RUN exit conditions:
  - halt=1 → DONE, done←1.
  - Otherwise, cycle_cnt==MAX_CYC−1 → DONE, timeout←1.
  - If both hold in the same cycle, halt wins: done=1, timeout=0.
- cycle_cnt holds its value in DONE. DONE→IDLE when run_req=0. The FIFO contents and flags survive into IDLE.
- Capture happens in RUN only, including the halt cycle and the final timeout cycle.
  - The lowest-indexed asserted ch_valid is written to the FIFO as {channel, data}.
  - Each other asserted valid in that cycle adds 1 to drop_cnt, saturating at all-ones.
  - A write while full, with no pop in the same cycle, is discarded and sets overflow.
- FIFO pointers are $clog2(TRACE_DEPTH)+1 bits and wrap naturally.
  - A pop when empty is ignored.
  - Pop+write when full: both are accepted.
  - Pop+write when empty: the write is accepted and the pop is ignored.

## Timing
- Reset values: state=IDLE, core_rst_n=0, start=0, busy=0, done=0, timeout=0, overflow=0, cycle_cnt=0, drop_cnt=0, FIFO empty (trace_empty=1, trace_full=0, trace_data=0, trace_ch=0).
- In IDLE after reset, core_rst_n=1.
- Latency:
  - run_req seen in IDLE → PRE on the next edge.
  - From PRE entry, start rises after PRE_RST_CYC+RST_CYC+SETTLE_CYC cycles.
  - RUN without halt lasts exactly MAX_CYC cycles.
- Status timing:
  - done/timeout rise on the edge that enters DONE.
  - trace_empty deasserts on the edge after the first capture.
  - trace_data is valid combinationally from the head entry whenever !trace_empty.
- rst_n assertion at any point returns everything to reset values immediately (asynchronously), including mid-RUN.

## Configuration
- RUN_CTRL_TRACE_EN defined: FIFO, arbitration, drop_cnt and overflow are present as described.
- Not defined: no storage is instantiated. trace_empty=1, trace_full=0, trace_data=0, trace_ch=0, overflow=0 and drop_cnt=0 constantly; trace_rd is ignored. The sequencer behaves identically.

## Test plan
- Defaults, run_req=1 held, halt=0 → core_rst_n low exactly 2 cycles starting 4 cycles after PRE entry; start high 60 cycles; then timeout=1, done=0, cycle_cnt=59.
- halt=1 on RUN cycle 10 → next edge: DONE, done=1, timeout=0, start=0, cycle_cnt=10. halt on cycle 59 → done=1, timeout=0.
- ch_valid=2'b11 with data 0xA/0xB in one RUN cycle → FIFO holds {ch0, 0xA}, drop_cnt=1. Next cycle ch_valid=2'b10 with 0xC → {ch1, 0xC} follows in order.
- 17 single-channel captures, no pops, TRACE_DEPTH=16 → trace_full after the 16th, overflow=1, 17th lost; 16 pops return entries 1–16 in order, then trace_empty=1.
- Simultaneous trace_rd and capture on a full FIFO → count unchanged, no overflow. Same on an empty FIFO → one entry present.
- rst_n pulsed low mid-RUN with 5 entries stored → all outputs at reset values within the same cycle, FIFO empty. Repeat with RUN_CTRL_TRACE_EN undefined → trace outputs are constant.

Source files
------------

// File: rtl/run_ctrl_if.sv
// Channel-monitor and trace-read bundle between the core side and run_ctrl.
// master: core/host side; slave: run_ctrl.
interface run_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
  logic                         trace_rd;
  logic [DATA_WIDTH-1:0]        trace_data;
  logic [CW-1:0]                trace_ch;
  logic                         trace_empty;
  logic                         trace_full;

  modport master (
    output ch_valid, ch_data, trace_rd,
    input  trace_data, trace_ch, trace_empty, trace_full
  );

  modport slave (
    input  ch_valid, ch_data, trace_rd,
    output trace_data, trace_ch, trace_empty, trace_full
  );
endinterface

// File: rtl/run_ctrl.sv
// Core run sequencer (pre-idle, reset pulse, settle, cycle-limited run) with trace.
// Trace FIFO/arbiter present only when RUN_CTRL_TRACE_EN is defined.
module run_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int PRE_RST_CYC = 4,
  parameter int RST_CYC     = 2,
  parameter int SETTLE_CYC  = 2,
  parameter int MAX_CYC     = 60,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_req,
  input  logic                 halt,
  run_ctrl_if.slave            tif,
  output logic                 core_rst_n,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, PRE, RST, SETTLE, RUN, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] phase_q, phase_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 crst_q;
  logic                 clr;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: if (run_req) begin
        state_d = PRE;
        phase_d = CNT_WIDTH'(PRE_RST_CYC - 1);
        cyc_d   = '0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        clr     = 1'b1;
      end
      PRE: if (phase_q == '0) begin
        state_d = RST;
        phase_d = CNT_WIDTH'(RST_CYC - 1);
      end else phase_d = phase_q - CNT_WIDTH'(1);
      RST: if (phase_q == '0) begin
        state_d = SETTLE;
        phase_d = CNT_WIDTH'(SETTLE_CYC - 1);
      end else phase_d = phase_q - CNT_WIDTH'(1);
      SETTLE: if (phase_q == '0) state_d = RUN;
        else phase_d = phase_q - CNT_WIDTH'(1);
      RUN: if (halt) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else if (cyc_q == CNT_WIDTH'(MAX_CYC - 1)) begin
        state_d = DONE;
        tmo_d   = 1'b1;
      end else cyc_d = cyc_q + CNT_WIDTH'(1);
      DONE: if (!run_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // core reset registered from the next state so it is a clean flop output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      crst_q  <= (state_d != RST);
    end
  end

  assign core_rst_n = crst_q;
  assign start      = (state_q == RUN);
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = done_q;
  assign timeout    = tmo_q;
  assign cycle_cnt  = cyc_q;

`ifdef RUN_CTRL_TRACE_EN
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(TRACE_DEPTH);

  logic [CW-1:0]            sel;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [CNT_WIDTH:0]       nval, dsum;
  logic [AW:0]              wr_q, wr_d, rd_q, rd_d;
  logic [CNT_WIDTH-1:0]     drop_q, drop_d;
  logic                     ovf_q, ovf_d;
  logic                     cap, empty, full, do_pop, do_wr;
  logic [CW+DATA_WIDTH-1:0] mem [TRACE_DEPTH];
  logic [CW+DATA_WIDTH-1:0] head;

  // descending scan so the lowest asserted channel wins
  always_comb begin
    sel      = '0;
    sel_data = '0;
    nval     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (tif.ch_valid[i]) begin
        sel      = CW'(i);
        sel_data = tif.ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      nval = nval + (CNT_WIDTH+1)'(tif.ch_valid[i]);
  end

  assign cap    = (state_q == RUN) && (|tif.ch_valid);
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = tif.trace_rd && !empty;
  assign do_wr  = cap && (!full || do_pop);
  assign dsum   = {1'b0, drop_q} + (nval - (CNT_WIDTH+1)'(1));

  always_comb begin
    wr_d   = wr_q + (AW+1)'(do_wr);
    rd_d   = rd_q + (AW+1)'(do_pop);
    ovf_d  = ovf_q | (cap && full && !do_pop);
    drop_d = drop_q;
    if (cap) drop_d = dsum[CNT_WIDTH] ? '1 : dsum[CNT_WIDTH-1:0];
    if (clr) begin
      wr_d   = '0;
      rd_d   = '0;
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_q[AW-1:0]] <= {sel, sel_data};
  end

  assign head            = mem[rd_q[AW-1:0]];
  assign tif.trace_data  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign tif.trace_ch    = empty ? '0 : head[CW+DATA_WIDTH-1:DATA_WIDTH];
  assign tif.trace_empty = empty;
  assign tif.trace_full  = full;
  assign overflow        = ovf_q;
  assign drop_cnt        = drop_q;
`else
  logic unused_trace;
  assign unused_trace    = ^{tif.ch_valid, tif.ch_data, tif.trace_rd, clr};
  assign tif.trace_data  = '0;
  assign tif.trace_ch    = '0;
  assign tif.trace_empty = 1'b1;
  assign tif.trace_full  = 1'b0;
  assign overflow        = 1'b0;
  assign drop_cnt        = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl at default parameters.
// Trace scenarios follow the RUN_CTRL_TRACE_EN build setting.
module tb_run_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_req = 1'b0;
  logic        halt = 1'b0;
  logic        core_rst_n, start, busy, done, timeout, overflow;
  logic [15:0] cycle_cnt, drop_cnt;
  int          tests = 0;
  int          fails = 0;

  run_ctrl_if #(.DATA_WIDTH(32), .NUM_CH(2)) tif ();

  run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt(halt),
    .tif(tif), .core_rst_n(core_rst_n), .start(start), .busy(busy),
    .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run();
    run_req = 1'b1;
    step(9);
    tests++;
    if (start !== 1'b1 || cycle_cnt !== 16'd0) begin
      fails++;
      $display("FAIL start_run: start=%b cnt=%0d want 1/0", start, cycle_cnt);
    end
  endtask

  task automatic end_run();
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    run_req = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    tif.ch_valid = '0;
    tif.ch_data = '0;
    tif.trace_rd = 1'b0;
    rst_n = 1'b0;
    #2;
    tests++;
    if ({core_rst_n, start, busy, done, timeout, overflow} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000000",
               {core_rst_n, start, busy, done, timeout, overflow});
    end
    tests++;
    if (cycle_cnt !== 0 || drop_cnt !== 0) begin
      fails++;
      $display("FAIL reset_cnts: cyc=%0d drop=%0d want 0", cycle_cnt, drop_cnt);
    end
    tests++;
    if ({tif.trace_empty, tif.trace_full, tif.trace_ch} !== 3'b100 ||
        tif.trace_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_trace: e=%b f=%b ch=%b d=%0h want 1/0/0/0",
               tif.trace_empty, tif.trace_full, tif.trace_ch, tif.trace_data);
    end
    #10 rst_n = 1'b1;
    step(2);
    tests++;
    if (core_rst_n !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: crst=%b busy=%b want 1/0", core_rst_n, busy);
    end
  endtask

  task automatic test_timeout();
    int first_low = -1, lows = 0, first_st = -1, highs = 0;
    run_req = 1'b1;
    for (int k = 1; k <= 69; k++) begin
      step(1);
      if (!core_rst_n) begin
        lows++;
        if (first_low < 0) first_low = k;
      end
      if (start) begin
        highs++;
        if (first_st < 0) first_st = k;
      end
    end
    tests++;
    if (lows !== 2 || first_low !== 5) begin
      fails++;
      $display("FAIL rst_pulse: lows=%0d first=%0d want 2/5", lows, first_low);
    end
    tests++;
    if (highs !== 60 || first_st !== 9) begin
      fails++;
      $display("FAIL start_len: highs=%0d first=%0d want 60/9", highs, first_st);
    end
    tests++;
    if (timeout !== 1'b1 || done !== 1'b0 || cycle_cnt !== 16'd59 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_end: tmo=%b done=%b cnt=%0d busy=%b want 1/0/59/0",
               timeout, done, cycle_cnt, busy);
    end
    run_req = 1'b0;
    step(1);
    tests++;
    if (timeout !== 1'b1 || busy !== 1'b0 || core_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL timeout_idle: tmo=%b busy=%b crst=%b want 1/0/1",
               timeout, busy, core_rst_n);
    end
  endtask

  task automatic test_halt(input int cyc);
    start_run();
    step(cyc);
    tests++;
    if (cycle_cnt !== 16'(cyc)) begin
      fails++;
      $display("FAIL halt_pre_%0d: cnt=%0d want %0d", cyc, cycle_cnt, cyc);
    end
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    tests++;
    if (done !== 1'b1 || timeout !== 1'b0 || start !== 1'b0 || cycle_cnt !== 16'(cyc)) begin
      fails++;
      $display("FAIL halt_%0d: done=%b tmo=%b start=%b cnt=%0d want 1/0/0/%0d",
               cyc, done, timeout, start, cycle_cnt, cyc);
    end
    step(2);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || cycle_cnt !== 16'(cyc)) begin
      fails++;
      $display("FAIL halt_hold_%0d: done=%b busy=%b cnt=%0d", cyc, done, busy, cycle_cnt);
    end
    run_req = 1'b0;
    step(1);
  endtask

`ifdef RUN_CTRL_TRACE_EN
  task automatic test_arbitration();
    start_run();
    tif.ch_valid = 2'b11;
    tif.ch_data = {32'hB, 32'hA};
    step(1);
    tif.ch_valid = 2'b10;
    tif.ch_data = {32'hC, 32'h0};
    tests++;
    if (tif.trace_empty !== 1'b0 || tif.trace_ch !== 1'b0 ||
        tif.trace_data !== 32'hA || drop_cnt !== 16'd1) begin
      fails++;
      $display("FAIL arb_first: e=%b ch=%b d=%0h drop=%0d want 0/0/a/1",
               tif.trace_empty, tif.trace_ch, tif.trace_data, drop_cnt);
    end
    step(1);
    tif.ch_valid = 2'b00;
    tif.trace_rd = 1'b1;
    step(1);
    tif.trace_rd = 1'b0;
    tests++;
    if (tif.trace_ch !== 1'b1 || tif.trace_data !== 32'hC || drop_cnt !== 16'd1) begin
      fails++;
      $display("FAIL arb_second: ch=%b d=%0h drop=%0d want 1/c/1",
               tif.trace_ch, tif.trace_data, drop_cnt);
    end
    end_run();
  endtask

  task automatic test_overflow();
    start_run();
    tif.ch_valid = 2'b01;
    for (int i = 1; i <= 17; i++) begin
      tif.ch_data = {32'h0, 32'(i)};
      step(1);
      if (i == 16) begin
        tests++;
        if (tif.trace_full !== 1'b1 || overflow !== 1'b0) begin
          fails++;
          $display("FAIL full_16: full=%b ovf=%b want 1/0", tif.trace_full, overflow);
        end
      end
    end
    tif.ch_valid = 2'b00;
    tests++;
    if (tif.trace_full !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_17: full=%b ovf=%b want 1/1", tif.trace_full, overflow);
    end
    end_run();
    for (int i = 1; i <= 16; i++) begin
      tests++;
      if (tif.trace_data !== 32'(i) || tif.trace_ch !== 1'b0) begin
        fails++;
        $display("FAIL pop_%0d: d=%0d ch=%b want %0d/0", i, tif.trace_data, tif.trace_ch, i);
      end
      tif.trace_rd = 1'b1;
      step(1);
      tif.trace_rd = 1'b0;
    end
    tests++;
    if (tif.trace_empty !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL drained: e=%b ovf=%b want 1/1", tif.trace_empty, overflow);
    end
  endtask

  task automatic test_simultaneous();
    start_run();
    tests++;
    if (tif.trace_empty !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL clear_on_run: e=%b ovf=%b want 1/0", tif.trace_empty, overflow);
    end
    tif.ch_valid = 2'b01;
    for (int i = 0; i < 16; i++) begin
      tif.ch_data = {32'h0, 32'(100 + i)};
      step(1);
    end
    tif.ch_data = {32'h0, 32'h55};
    tif.trace_rd = 1'b1;
    step(1);
    tif.trace_rd = 1'b0;
    tif.ch_valid = 2'b00;
    tests++;
    if (tif.trace_full !== 1'b1 || overflow !== 1'b0 || tif.trace_data !== 32'd101) begin
      fails++;
      $display("FAIL full_rw: full=%b ovf=%b d=%0d want 1/0/101",
               tif.trace_full, overflow, tif.trace_data);
    end
    end_run();
    tif.trace_rd = 1'b1;
    step(15);
    tif.trace_rd = 1'b0;
    tests++;
    if (tif.trace_data !== 32'h55) begin
      fails++;
      $display("FAIL full_rw_tail: d=%0h want 55", tif.trace_data);
    end
    start_run();
    tif.ch_valid = 2'b01;
    tif.ch_data = {32'h0, 32'h77};
    tif.trace_rd = 1'b1;
    step(1);
    tif.trace_rd = 1'b0;
    tif.ch_valid = 2'b00;
    tests++;
    if (tif.trace_empty !== 1'b0 || tif.trace_data !== 32'h77 || tif.trace_full !== 1'b0) begin
      fails++;
      $display("FAIL empty_rw: e=%b d=%0h f=%b want 0/77/0",
               tif.trace_empty, tif.trace_data, tif.trace_full);
    end
    tif.trace_rd = 1'b1;
    step(1);
    tif.trace_rd = 1'b0;
    tests++;
    if (tif.trace_empty !== 1'b1) begin
      fails++;
      $display("FAIL empty_rw_pop: e=%b want 1", tif.trace_empty);
    end
    end_run();
  endtask
`else
  task automatic test_trace_off();
    start_run();
    for (int i = 0; i < 4; i++) begin
      tif.ch_valid = 2'b11;
      tif.ch_data = {32'(i + 1), 32'(i + 9)};
      tif.trace_rd = i[0];
      step(1);
      tests++;
      if (tif.trace_empty !== 1'b1 || tif.trace_full !== 1'b0 || tif.trace_ch !== 1'b0 ||
          tif.trace_data !== 0 || overflow !== 1'b0 || drop_cnt !== 0) begin
        fails++;
        $display("FAIL trace_off_%0d: e=%b f=%b ch=%b d=%0h ovf=%b drop=%0d", i,
                 tif.trace_empty, tif.trace_full, tif.trace_ch, tif.trace_data,
                 overflow, drop_cnt);
      end
    end
    tif.ch_valid = 2'b00;
    tif.trace_rd = 1'b0;
    end_run();
  endtask
`endif

  task automatic test_async_reset();
    start_run();
    tif.ch_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tif.ch_data = {32'h0, 32'(i + 1)};
      step(1);
    end
    tif.ch_valid = 2'b00;
    step(2);
    tests++;
    if (start !== 1'b1 || cycle_cnt !== 16'd7) begin
      fails++;
      $display("FAIL pre_areset: start=%b cnt=%0d want 1/7", start, cycle_cnt);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({core_rst_n, start, busy, done, timeout, overflow} !== 6'b0 ||
        cycle_cnt !== 0 || drop_cnt !== 0) begin
      fails++;
      $display("FAIL areset_seq: flags=%b cnt=%0d drop=%0d want 0",
               {core_rst_n, start, busy, done, timeout, overflow}, cycle_cnt, drop_cnt);
    end
    tests++;
    if (tif.trace_empty !== 1'b1 || tif.trace_full !== 1'b0 ||
        tif.trace_data !== 0 || tif.trace_ch !== 1'b0) begin
      fails++;
      $display("FAIL areset_trace: e=%b f=%b d=%0h ch=%b want 1/0/0/0",
               tif.trace_empty, tif.trace_full, tif.trace_data, tif.trace_ch);
    end
    run_req = 1'b0;
    #3 rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_halt(10);
    test_halt(59);
`ifdef RUN_CTRL_TRACE_EN
    test_arbitration();
    test_overflow();
    test_simultaneous();
`else
    test_trace_off();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
